// File: rtl/mlp_param_stream_loader_if.sv
// rtl/mlp_param_stream_loader_if.sv - parameter, sample and result handshakes of the MLP stream loader
interface mlp_param_stream_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        infer_valid;
  logic        infer_ready;
  logic [31:0] infer_data;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_class;

  modport master (
    output s_valid, s_data, infer_valid, infer_data, res_ready,
    input  s_ready, infer_ready, res_valid, res_class
  );

  modport slave (
    input  s_valid, s_data, infer_valid, infer_data, res_ready,
    output s_ready, infer_ready, res_valid, res_class
  );
endinterface

// File: rtl/mlp_param_stream_loader.sv
// rtl/mlp_param_stream_loader.sv - streams weights/biases into the 8-3-3 MLP and sequences one inference at a time
module mlp_param_stream_loader #(
  parameter int W_BYTES     = 33,
  parameter int B_BYTES     = 9,
  parameter int EVAL_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  mlp_param_stream_loader_if.slave bus,
  output logic                   params_valid,
  output logic [8*W_BYTES-1:0]   weights,
  output logic [8*B_BYTES-1:0]   biases,
  output logic [31:0]            inp,
  input  logic [1:0]             class_in
);

  localparam int MAXB = (W_BYTES > B_BYTES) ? W_BYTES : B_BYTES;
  localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;

  typedef enum logic [1:0] {L_IDLE, L_W, L_B, L_DONE} load_state_t;
  typedef enum logic [1:0] {I_IDLE, I_EVAL, I_RESP} infer_state_t;

  load_state_t  lstate;
  infer_state_t istate;
  logic [CW-1:0] byte_cnt;
  logic [3:0]    eval_cnt;
  logic          load_go;
  logic          s_xfer;
  logic          i_xfer;

  // Reloading is only legal between inferences so the classifier inputs never move under a sample.
  assign load_go         = load_start && (istate == I_IDLE);
  assign s_xfer          = bus.s_valid && bus.s_ready;
  assign bus.infer_ready = params_valid && (istate == I_IDLE) && !load_start;
  assign i_xfer          = bus.infer_valid && bus.infer_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      lstate       <= L_IDLE;
      byte_cnt     <= '0;
      bus.s_ready  <= 1'b0;
      params_valid <= 1'b0;
      weights      <= '0;
      biases       <= '0;
    end else if (load_go) begin
      lstate       <= L_W;
      byte_cnt     <= '0;
      bus.s_ready  <= 1'b1;
      params_valid <= 1'b0;
    end else begin
      case (lstate)
        L_W: begin
          if (s_xfer) begin
            for (int k = 0; k < W_BYTES; k++) begin
              if (byte_cnt == CW'(k)) weights[8*k +: 8] <= bus.s_data;
            end
            if (byte_cnt == CW'(W_BYTES - 1)) begin
              lstate   <= L_B;
              byte_cnt <= '0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        L_B: begin
          if (s_xfer) begin
            for (int k = 0; k < B_BYTES; k++) begin
              if (byte_cnt == CW'(k)) biases[8*k +: 8] <= bus.s_data;
            end
            if (byte_cnt == CW'(B_BYTES - 1)) begin
              lstate       <= L_DONE;
              bus.s_ready  <= 1'b0;
              params_valid <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // class_in is combinational from inp, so it is sampled only after EVAL_CYCLES of settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      istate        <= I_IDLE;
      eval_cnt      <= '0;
      inp           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_class <= 2'b00;
    end else begin
      case (istate)
        I_IDLE: begin
          if (i_xfer) begin
            inp      <= bus.infer_data;
            eval_cnt <= '0;
            istate   <= I_EVAL;
          end
        end
        I_EVAL: begin
          if (eval_cnt == 4'(EVAL_CYCLES - 1)) begin
            bus.res_class <= class_in;
            bus.res_valid <= 1'b1;
            istate        <= I_RESP;
          end else begin
            eval_cnt <= eval_cnt + 4'd1;
          end
        end
        I_RESP: begin
          if (bus.res_valid && bus.res_ready) begin
            bus.res_valid <= 1'b0;
            istate        <= I_IDLE;
          end
        end
        default: istate <= I_IDLE;
      endcase
    end
  end

endmodule
